// File: rtl/scd_exec_core.sv
// SCD execute core: decode ROM, 16x8 register file, 8-bit ALU.
// Decode, ALU and write-back are combinational; only registers are clocked.
module scd_exec_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inst,
  input  logic        exec,
  input  logic [6:0]  pc,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  rd1,
  output logic [7:0]  rd2,
  output logic [7:0]  alu_out,
  output logic [2:0]  alu_flags,
  output logic [7:0]  wb_data,
  output logic        wpc,
  output logic        spc,
  output logic        mem_we,
  output logic        mem_re,
  output logic        ldi
);

  logic [3:0] op, rd, ra, rb;
  logic [7:0] imm;
  logic [7:0] alu_ctl;
  logic [4:0] ctl;

  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic       we;

  logic       za, na, zb, nb, f, no, cin, shr;
  logic [7:0] a1, a2, b1, b2, res, r;
  logic [8:0] sum;
  logic       cy, carry;

  assign op  = inst[15:12];
  assign rd  = inst[11:8];
  assign ra  = inst[7:4];
  assign rb  = inst[3:0];
  assign imm = inst[7:0];

  // Opcode ROM: ALU control word and control strobes
  always_comb begin
    alu_ctl = 8'h00;
    ctl     = 5'h00;
    unique case (op)
      4'h1:    alu_ctl = 8'h08;
      4'h2:    alu_ctl = 8'h1A;
      4'h3:    alu_ctl = 8'h54;
      4'h4:    alu_ctl = 8'h34;
      4'h5:    alu_ctl = 8'h2A;
      4'h6:    alu_ctl = 8'h38;
      4'h7:    alu_ctl = 8'h31;
      4'h8:    alu_ctl = 8'h30;
      4'h9:    ctl     = 5'h01;
      4'hA: begin
        alu_ctl = 8'h30;
        ctl     = 5'h02;
      end
      4'hB: begin
        alu_ctl = 8'h30;
        ctl     = 5'h04;
      end
      4'hC: begin
        alu_ctl = 8'h30;
        ctl     = 5'h18;
      end
      default: begin
        alu_ctl = 8'h00;
        ctl     = 5'h00;
      end
    endcase
  end

  assign {wpc, spc, mem_we, mem_re, ldi} = ctl;
  assign {za, na, zb, nb, f, no, cin, shr} = alu_ctl;

  assign rd1 = regs_q[ra];
  assign rd2 = regs_q[rb];

  // Configurable ALU: operand zero/invert, add or and, invert, shift
  always_comb begin
    a1    = za ? 8'h00 : rd1;
    a2    = na ? ~a1 : a1;
    b1    = zb ? 8'h00 : rd2;
    b2    = nb ? ~b1 : b1;
    sum   = {1'b0, a2} + {1'b0, b2} + {8'h00, cin};
    res   = f ? sum[7:0] : (a2 & b2);
    cy    = f ? sum[8] : 1'b0;
    r     = no ? ~res : res;
    alu_out = shr ? {1'b0, r[7:1]} : r;
    carry = shr ? r[0] : cy;
    alu_flags = {(alu_out == 8'h00), alu_out[7], carry};
  end

  // Write-back select: link address, immediate, memory byte, ALU
  always_comb begin
    if (spc)
      wb_data = {pc, 1'b0};
    else if (ldi)
      wb_data = imm;
    else if (mem_re)
      wb_data = rd1[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    else
      wb_data = alu_out;
  end

  assign we = exec & ~mem_we;

  // Next register file contents: one write port addressed by rd
  always_comb begin
    regs_d = regs_q;
    if (we)
      regs_d[rd] = wb_data;
  end

  // Register file state, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        regs_q[i] <= 8'h00;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_scd_exec_core.sv
// Bench for scd_exec_core: directed program steps plus random
// instructions checked against an instruction-level reference model.
module tb_scd_exec_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inst;
  logic        exec;
  logic [6:0]  pc;
  logic [15:0] mem_rdata;
  logic [7:0]  rd1, rd2, alu_out, wb_data;
  logic [2:0]  alu_flags;
  logic        wpc, spc, mem_we, mem_re, ldi;

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [16];

  scd_exec_core dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .exec(exec), .pc(pc),
    .mem_rdata(mem_rdata), .rd1(rd1), .rd2(rd2), .alu_out(alu_out),
    .alu_flags(alu_flags), .wb_data(wb_data), .wpc(wpc), .spc(spc),
    .mem_we(mem_we), .mem_re(mem_re), .ldi(ldi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction semantics in terms of what each opcode means
  function automatic void ref_model(
      input logic [15:0] i, input logic [7:0] a, input logic [7:0] b,
      input logic [6:0] p, input logic [15:0] m,
      output logic [7:0] alu, output logic [2:0] flg,
      output logic [7:0] wb, output logic [4:0] strb,
      output logic wr);
    logic c;
    logic [8:0] s;
    c = 1'b0;
    strb = 5'b0;
    case (i[15:12])
      4'h1: begin s = a + b; alu = s[7:0]; c = s[8]; end
      4'h2: begin alu = a - b; c = (a >= b); end
      4'h3: alu = a | b;
      4'h4: alu = ~a;
      4'h5: begin alu = a + 8'd1; c = (a == 8'hFF); end
      4'h6: begin alu = a - 8'd1; c = (a != 8'h00); end
      4'h7: begin alu = a >> 1; c = a[0]; end
      4'h8, 4'hA, 4'hB, 4'hC: alu = a;
      default: alu = a & b;
    endcase
    flg = {(alu == 8'h00), alu[7], c};
    case (i[15:12])
      4'h9: strb = 5'b00001;
      4'hA: strb = 5'b00010;
      4'hB: strb = 5'b00100;
      4'hC: strb = 5'b11000;
      default: strb = 5'b00000;
    endcase
    case (i[15:12])
      4'hC: wb = {p, 1'b0};
      4'h9: wb = i[7:0];
      4'hA: wb = a[0] ? m[15:8] : m[7:0];
      default: wb = alu;
    endcase
    wr = (i[15:12] != 4'hB);
  endfunction

  // One instruction: drive, check all outputs, clock, update model
  task automatic apply(input logic [15:0] i, input logic e,
                       input logic [6:0] p, input logic [15:0] m);
    logic [7:0] ea, ewb;
    logic [2:0] ef;
    logic [4:0] es;
    logic wr;
    @(negedge clk);
    inst = i;
    exec = e;
    pc = p;
    mem_rdata = m;
    #1;
    ref_model(i, mdl[i[7:4]], mdl[i[3:0]], p, m, ea, ef, ewb, es, wr);
    chk("rd1", {8'h0, rd1}, {8'h0, mdl[i[7:4]]});
    chk("rd2", {8'h0, rd2}, {8'h0, mdl[i[3:0]]});
    chk("alu_out", {8'h0, alu_out}, {8'h0, ea});
    chk("flags", {13'h0, alu_flags}, {13'h0, ef});
    chk("wb_data", {8'h0, wb_data}, {8'h0, ewb});
    chk("strobes", {11'h0, wpc, spc, mem_we, mem_re, ldi}, {11'h0, es});
    @(posedge clk);
    if (e && wr && rst_n)
      mdl[i[11:8]] = ewb;
  endtask

  // Read one register through both ports with writes disabled
  task automatic check_reg(input logic [3:0] r, input logic [7:0] v);
    @(negedge clk);
    inst = {4'h8, 4'h0, r, r};
    exec = 1'b0;
    #1;
    chk($sformatf("reg%0d_rd1", r), {8'h0, rd1}, {8'h0, v});
    chk($sformatf("reg%0d_rd2", r), {8'h0, rd2}, {8'h0, v});
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
    inst = 16'h0000;
    exec = 1'b0;
    pc = 7'h00;
    mem_rdata = 16'h0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_rd1", {8'h0, rd1}, 16'h0000);
    chk("rst_alu", {8'h0, alu_out}, 16'h0000);
    chk("rst_wb", {8'h0, wb_data}, 16'h0000);
    chk("rst_flags", {13'h0, alu_flags}, 16'h0004);
    chk("rst_strobes", {11'h0, wpc, spc, mem_we, mem_re, ldi}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LDI + ADD with carry out
    apply(16'h91F0, 1'b1, 7'h00, 16'h0000);
    apply(16'h9220, 1'b1, 7'h01, 16'h0000);
    apply(16'h1312, 1'b1, 7'h02, 16'h0000);
    check_reg(4'd3, 8'h10);
    // SUB equal and borrowing
    apply(16'h9120, 1'b1, 7'h03, 16'h0000);
    apply(16'h2412, 1'b1, 7'h04, 16'h0000);
    check_reg(4'd4, 8'h00);
    apply(16'h9110, 1'b1, 7'h05, 16'h0000);
    apply(16'h2412, 1'b1, 7'h06, 16'h0000);
    check_reg(4'd4, 8'hF0);
    // OR, NOT, SHR
    apply(16'h91F0, 1'b1, 7'h07, 16'h0000);
    apply(16'h920F, 1'b1, 7'h08, 16'h0000);
    apply(16'h3312, 1'b1, 7'h09, 16'h0000);
    check_reg(4'd3, 8'hFF);
    apply(16'h4410, 1'b1, 7'h0A, 16'h0000);
    check_reg(4'd4, 8'h0F);
    apply(16'h9103, 1'b1, 7'h0B, 16'h0000);
    apply(16'h7710, 1'b1, 7'h0C, 16'h0000);
    check_reg(4'd7, 8'h01);
    // LD byte select, ST
    apply(16'h9111, 1'b1, 7'h0D, 16'h0000);
    apply(16'hA510, 1'b1, 7'h0E, 16'hAB34);
    check_reg(4'd5, 8'hAB);
    apply(16'h9110, 1'b1, 7'h0F, 16'h0000);
    apply(16'hA510, 1'b1, 7'h10, 16'hAB34);
    check_reg(4'd5, 8'h34);
    apply(16'hB512, 1'b1, 7'h11, 16'h0000);
    check_reg(4'd5, 8'h34);
    // JAL link
    apply(16'h9140, 1'b1, 7'h12, 16'h0000);
    apply(16'hC610, 1'b1, 7'h05, 16'h0000);
    check_reg(4'd6, 8'h0A);
    // exec gating
    apply(16'h1812, 1'b0, 7'h13, 16'h0000);
    check_reg(4'd8, 8'h00);
    // INC held three cycles
    apply(16'h9110, 1'b1, 7'h14, 16'h0000);
    apply(16'h5110, 1'b1, 7'h15, 16'h0000);
    apply(16'h5110, 1'b1, 7'h15, 16'h0000);
    apply(16'h5110, 1'b1, 7'h15, 16'h0000);
    check_reg(4'd1, 8'h13);

    // Random instructions against the model
    for (int n = 0; n < 200; n++)
      apply(16'($urandom), 1'($urandom_range(0, 3) != 0),
            7'($urandom), 16'($urandom));
    for (int k = 0; k < 16; k++)
      check_reg(4'(k), mdl[k]);

    // Reset mid-sequence discards a pending write across an edge
    @(negedge clk);
    inst = 16'h5110;
    exec = 1'b1;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_hold_rd1", {8'h0, rd1}, 16'h0000);
    for (int k = 0; k < 16; k++)
      check_reg(4'(k), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(16'h5110, 1'b1, 7'h00, 16'h0000);
    check_reg(4'd1, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
